// File: rtl/axi_pkg.sv
// AXI read responder shared types.
// Burst kinds, response codes, responder states and wrap helpers.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATENCY = 2'd1,
    ST_BURST   = 2'd2
  } rsp_state_e;

  // byte mask covering one whole wrap block of len+1 beats
  function automatic logic [11:0] wrap_mask(input logic [7:0] len);
    logic [11:0] span;
    span = ({4'd0, len} + 12'd1) << 3;
    return span - 12'd1;
  endfunction

  // wrap bursts must be 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for INCR and WRAP bursts.
// Pure combinational; the responder registers the result.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] incr;

  // wrap keeps the block base and rotates the offset inside it
  always_comb begin
    mask      = ADDR_WIDTH'(wrap_mask(len));
    incr      = addr + ADDR_WIDTH'(8);
    next_addr = incr;
    if (burst == BURST_WRAP) begin
      next_addr = (addr & ~mask) | (incr & mask);
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI read responder over a preloadable memory.
// AR accept, fixed latency, then arlen+1 beats with held rdata.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 4,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         m_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  input  logic [7:0]                   m_axi_arlen,
  input  logic [2:0]                   m_axi_arsize,
  input  logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arready,
  output logic                         m_axi_rvalid,
  output logic [63:0]                  m_axi_rdata,
  output logic [1:0]                   m_axi_rresp,
  output logic                         m_axi_rlast,
  input  logic                         m_axi_rready,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [63:0]                  load_data
);

  localparam int IW  = $clog2(MEM_WORDS);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LIMIT = AW1'(MEM_WORDS) << 3;
  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  logic [63:0] mem [MEM_WORDS];

  rsp_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            burst_q, burst_d;
  logic [1:0]            err_q, err_d;
  logic [3:0]            lat_q, lat_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  arready_q, arready_d;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IW-1:0]         rd_idx;
  logic [63:0]           rd_word;
  logic [ADDR_WIDTH-1:0] ar_mask;
  logic [AW1-1:0]        ar_last;
  logic                  ar_slverr;
  logic [1:0]            ar_err;
  logic                  last_beat;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr     (addr_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  // classify the request; decode range uses the highest beat address
  always_comb begin
    ar_mask   = ADDR_WIDTH'(wrap_mask(m_axi_arlen));
    ar_slverr = 1'b0;
    ar_last   = {1'b0, m_axi_araddr} +
                AW1'({m_axi_arlen, 3'b000});
    if (m_axi_arsize != 3'd3) begin
      ar_slverr = 1'b1;
    end else if (m_axi_arburst == BURST_WRAP) begin
      ar_slverr = !wrap_len_ok(m_axi_arlen);
      ar_last   = {1'b0, m_axi_araddr | ar_mask};
    end else if (m_axi_arburst != BURST_INCR) begin
      ar_slverr = 1'b1;
    end
    if (ar_slverr) begin
      ar_err = RESP_SLVERR;
    end else if (ar_last >= LIMIT) begin
      ar_err = RESP_DECERR;
    end else begin
      ar_err = RESP_OKAY;
    end
  end

  // single read port; same-edge loads forward into the fetched word
  always_comb begin
    rd_addr = (state_q == ST_BURST) ? next_addr : addr_q;
    rd_idx  = IW'(rd_addr >> 3);
    rd_word = mem[rd_idx];
    if (load_en && (load_addr == rd_idx)) begin
      rd_word = load_data;
    end
  end

  assign last_beat = (beat_q == len_q);

  // responder FSM: accept, wait out latency, stream beats
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = err_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_axi_arvalid && arready_q) begin
          addr_d  = m_axi_araddr;
          len_d   = m_axi_arlen;
          burst_d = m_axi_arburst;
          err_d   = ar_err;
          beat_d  = '0;
          lat_d   = LAT;
          state_d = ST_LATENCY;
        end
      end
      ST_LATENCY: begin
        if (lat_q <= 4'd1) begin
          state_d = ST_BURST;
          rdata_d = (err_q == RESP_OKAY) ? rd_word : '0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_BURST: begin
        if (m_axi_rready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            rdata_d = (err_q == RESP_OKAY) ? rd_word : '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE);
  end

  // state and holding registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      err_q     <= RESP_OKAY;
      beat_q    <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      arready_q <= arready_d;
    end
  end

  // preload write port, untouched by reset
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign m_axi_arready = arready_q;
  assign m_axi_rvalid  = (state_q == ST_BURST);
  assign m_axi_rdata   = rdata_q;
  assign m_axi_rresp   = m_axi_rvalid ? err_q : RESP_OKAY;
  assign m_axi_rlast   = m_axi_rvalid && last_beat;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder.
// Directed scenarios plus random bursts against a beat-list model.
module tb_axi_read_responder;

  localparam int MW  = 256;
  localparam int IW  = $clog2(MW);
  localparam int LAT = 4;
  localparam longint unsigned LIMIT = MW * 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready;
  logic        rvalid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rready;
  logic        load_en;
  logic [IW-1:0] load_addr;
  logic [63:0] load_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [63:0] tb_mem [MW];
  logic [63:0] got_d[$], exp_d[$], stall_d[$];
  logic [1:0]  got_r[$], exp_r[$];
  logic        got_l[$], exp_l[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  axi_read_responder #(
    .MEM_WORDS(MW),
    .READ_LATENCY(LAT),
    .ADDR_WIDTH(64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .m_axi_arvalid(arvalid),
    .m_axi_araddr (araddr),
    .m_axi_arlen  (arlen),
    .m_axi_arsize (arsize),
    .m_axi_arburst(arburst),
    .m_axi_arready(arready),
    .m_axi_rvalid (rvalid),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rlast  (rlast),
    .m_axi_rready (rready),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data)
  );

  task automatic load_word(input int idx, input logic [63:0] v);
    load_en   = 1'b1;
    load_addr = IW'(idx);
    load_data = v;
    @(negedge clock);
    load_en   = 1'b0;
    tb_mem[idx] = v;
  endtask

  // expected beats from the protocol rules: address list, then code
  function automatic void model(input logic [63:0] a,
                                input logic [7:0] l,
                                input logic [2:0] s,
                                input logic [1:0] b);
    int n;
    longint unsigned tot, base, ad;
    longint unsigned adr[$];
    logic [1:0] code;
    exp_d.delete(); exp_r.delete(); exp_l.delete();
    n    = int'(l) + 1;
    tot  = longint'(n) * 8;
    base = a - (a % tot);
    code = 2'd0;
    if (s != 3'd3) code = 2'd2;
    if (b != 2'd1 && b != 2'd2) code = 2'd2;
    if (b == 2'd2 && !(n inside {2, 4, 8, 16})) code = 2'd2;
    for (int i = 0; i < n; i++) begin
      if (b == 2'd2)
        ad = base + ((a - base + longint'(i) * 8) % tot);
      else
        ad = a + longint'(i) * 8;
      adr.push_back(ad);
    end
    if (code == 2'd0)
      foreach (adr[i]) if (adr[i] >= LIMIT) code = 2'd3;
    foreach (adr[i]) begin
      exp_d.push_back(code != 0 ? 64'd0 : tb_mem[(adr[i] >> 3) % MW]);
      exp_r.push_back(code);
      exp_l.push_back(i == n - 1);
    end
  endfunction

  // drive one AR and collect beats; optional stalls and abort by reset
  task automatic do_burst(input logic [63:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b,
                          input int pct, input int st_beat,
                          input int st_len, input int abort_at,
                          output int lat, output int holdbad,
                          output bit tmo);
    int h, g, nb, sc;
    bit done, hold, rr;
    logic [63:0] pd;
    logic [1:0] pr;
    logic pl;
    got_d.delete(); got_r.delete(); got_l.delete(); stall_d.delete();
    lat = -1; holdbad = 0; tmo = 0;
    nb = 0; sc = 0; done = 0; hold = 0; g = 0;
    pd = '0; pr = '0; pl = 1'b0;
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    while (arready !== 1'b1 && g < 50) begin
      @(negedge clock); g++;
    end
    if (g >= 50) begin
      arvalid = 1'b0; tmo = 1; return;
    end
    h = cyc;
    @(negedge clock);
    arvalid = 1'b0;
    g = 0;
    while (!done && g < 500) begin
      if (hold && (rvalid !== 1'b1 || rdata !== pd ||
                   rresp !== pr || rlast !== pl))
        holdbad++;
      rr = ($urandom_range(99) >= pct);
      if (rvalid === 1'b1) begin
        if (lat < 0) lat = cyc - h;
        if (nb == abort_at) begin
          reset = 1'b1; rready = 1'b0; return;
        end
        if (nb == st_beat && sc < st_len) begin
          rr = 0; sc++;
        end
        if (!rr) stall_d.push_back(rdata);
        else begin
          got_d.push_back(rdata);
          got_r.push_back(rresp);
          got_l.push_back(rlast);
          nb++;
          if (rlast === 1'b1) done = 1;
        end
      end
      hold = (rvalid === 1'b1) && !rr;
      pd = rdata; pr = rresp; pl = rlast;
      rready = rr;
      @(negedge clock); g++;
    end
    rready = 1'b0;
    if (!done) tmo = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0 ||
        rdata !== 64'd0 || rresp !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs got ar=%b rv=%b rl=%b rd=%h rr=%0d want 0",
               arready, rvalid, rlast, rdata, rresp);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (arready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_arready got %b want 1", arready);
    end
  endtask

  task automatic test_wrap();
    int lat, hb; bit tmo;
    logic [63:0] ew [8];
    ew = '{4, 5, 6, 7, 0, 1, 2, 3};
    do_burst(64'h20, 8'd7, 3'd3, 2'd2, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 8) begin
      fails++;
      $display("FAIL wrap_count got %0d (tmo=%0d) want 8", got_d.size(), tmo);
    end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      tests++;
      if (got_d[i] !== ew[i] || got_r[i] !== 2'd0 || got_l[i] !== (i == 7)) begin
        fails++;
        $display("FAIL wrap_beat%0d got d=%0d r=%0d l=%b want d=%0d r=0 l=%b",
                 i, got_d[i], got_r[i], got_l[i], ew[i], i == 7);
      end
    end
    tests++;
    if (lat != LAT + 1) begin
      fails++;
      $display("FAIL wrap_latency got %0d want %0d", lat, LAT + 1);
    end
  endtask

  task automatic test_incr();
    int lat, hb; bit tmo;
    do_burst(64'h38, 8'd3, 3'd3, 2'd1, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 4) begin
      fails++;
      $display("FAIL incr_count got %0d (tmo=%0d) want 4", got_d.size(), tmo);
    end
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      tests++;
      if (got_d[i] !== 64'(7 + i) || got_r[i] !== 2'd0 || got_l[i] !== (i == 3)) begin
        fails++;
        $display("FAIL incr_beat%0d got d=%0d r=%0d l=%b want d=%0d r=0 l=%b",
                 i, got_d[i], got_r[i], got_l[i], 7 + i, i == 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, hb; bit tmo;
    logic [63:0] ew [8];
    ew = '{4, 5, 6, 7, 0, 1, 2, 3};
    do_burst(64'h20, 8'd7, 3'd3, 2'd2, 0, 2, 3, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 8) begin
      fails++;
      $display("FAIL bp_count got %0d (tmo=%0d) want 8", got_d.size(), tmo);
    end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      tests++;
      if (got_d[i] !== ew[i] || got_l[i] !== (i == 7)) begin
        fails++;
        $display("FAIL bp_beat%0d got d=%0d l=%b want d=%0d l=%b",
                 i, got_d[i], got_l[i], ew[i], i == 7);
      end
    end
    tests++;
    if (stall_d.size() != 3 || hb != 0) begin
      fails++;
      $display("FAIL bp_hold got stalls=%0d holdbad=%0d want 3 and 0",
               stall_d.size(), hb);
    end
    foreach (stall_d[i]) begin
      tests++;
      if (stall_d[i] !== 64'd6) begin
        fails++;
        $display("FAIL bp_stall%0d got %0d want 6", i, stall_d[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat, hb; bit tmo;
    do_burst(64'h0, 8'd7, 3'd2, 2'd1, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 8) begin
      fails++;
      $display("FAIL slverr_count got %0d (tmo=%0d) want 8", got_d.size(), tmo);
    end
    foreach (got_d[i]) begin
      tests++;
      if (got_d[i] !== 64'd0 || got_r[i] !== 2'd2 || got_l[i] !== (i == 7)) begin
        fails++;
        $display("FAIL slverr_beat%0d got d=%0d r=%0d l=%b want d=0 r=2 l=%b",
                 i, got_d[i], got_r[i], got_l[i], i == 7);
      end
    end
    do_burst(64'(LIMIT), 8'd0, 3'd3, 2'd1, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 1 || got_r[0] !== 2'd3 ||
        got_d[0] !== 64'd0 || got_l[0] !== 1'b1) begin
      fails++;
      $display("FAIL decerr got n=%0d r=%0d d=%0d want n=1 r=3 d=0 l=1",
               got_d.size(), got_r.size() ? got_r[0] : 2'd0,
               got_d.size() ? got_d[0] : 64'd0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int lat, hb, n; bit tmo;
    do_burst(64'h20, 8'd7, 3'd3, 2'd2, 0, -1, 0, 2, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 2) begin
      fails++;
      $display("FAIL rst_mid_pre got %0d beats (tmo=%0d) want 2", got_d.size(), tmo);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abort got rv=%b ar=%b want 0 0", rvalid, arready);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (arready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_arready got %b want 1", arready);
    end
    n = 0;
    repeat (6) begin
      if (rvalid !== 1'b0) n++;
      @(negedge clock);
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL rst_mid_residual got %0d rvalid cycles want 0", n);
    end
    model(64'h20, 8'd7, 3'd3, 2'd2);
    do_burst(64'h20, 8'd7, 3'd3, 2'd2, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL rst_mid_count got %0d want %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      tests++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        fails++;
        $display("FAIL rst_mid_beat%0d got %0d want %0d", i, got_d[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_busy();
    int g, bad, lat, hb; bit done, tmo;
    logic [63:0] seen[$];
    araddr = 64'h0; arlen = 8'd3; arsize = 3'd3; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b1; g = 0;
    while (arready !== 1'b1 && g < 50) begin
      @(negedge clock); g++;
    end
    @(negedge clock);
    araddr = 64'h40; arlen = 8'd1;
    bad = 0; done = 0; g = 0;
    while (!done && g < 100) begin
      if (arready !== 1'b0) bad++;
      if (rvalid === 1'b1) begin
        seen.push_back(rdata);
        if (rlast === 1'b1) done = 1;
      end
      @(negedge clock); g++;
    end
    tests++;
    if (bad != 0 || !done) begin
      fails++;
      $display("FAIL busy_arready got %0d busy-ready cycles (done=%0d) want 0", bad, done);
    end
    tests++;
    if (arready !== 1'b1) begin
      fails++;
      $display("FAIL busy_reready got %b want 1", arready);
    end
    tests++;
    if (seen.size() != 4) begin
      fails++;
      $display("FAIL busy_first_count got %0d want 4", seen.size());
    end
    foreach (seen[i]) begin
      tests++;
      if (seen[i] !== 64'(i)) begin
        fails++;
        $display("FAIL busy_first%0d got %0d want %0d", i, seen[i], i);
      end
    end
    model(64'h40, 8'd1, 3'd3, 2'd1);
    do_burst(64'h40, 8'd1, 3'd3, 2'd1, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 2 || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1]) begin
      fails++;
      $display("FAIL busy_second got n=%0d tmo=%0d want %0d,%0d",
               got_d.size(), tmo, exp_d[0], exp_d[1]);
    end
  endtask

  task automatic test_load_hold();
    int g, lat, hb; bit tmo;
    logic [63:0] old;
    araddr = 64'h0; arlen = 8'd1; arsize = 3'd3; arburst = 2'd1;
    arvalid = 1'b1; rready = 1'b0; g = 0;
    while (arready !== 1'b1 && g < 50) begin
      @(negedge clock); g++;
    end
    @(negedge clock);
    arvalid = 1'b0; g = 0;
    while (rvalid !== 1'b1 && g < 50) begin
      @(negedge clock); g++;
    end
    old = tb_mem[0];
    tests++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      fails++;
      $display("FAIL ldhold_first got rv=%b d=%h want 1 %h", rvalid, rdata, old);
    end
    load_word(0, ~old);
    tests++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      fails++;
      $display("FAIL ldhold_stable got rv=%b d=%h want 1 %h", rvalid, rdata, old);
    end
    rready = 1'b1;
    @(negedge clock);
    tests++;
    if (rdata !== tb_mem[1] || rlast !== 1'b1) begin
      fails++;
      $display("FAIL ldhold_second got d=%h l=%b want %h 1", rdata, rlast, tb_mem[1]);
    end
    @(negedge clock);
    rready = 1'b0;
    do_burst(64'h0, 8'd0, 3'd3, 2'd1, 0, -1, 0, -1, lat, hb, tmo);
    tests++;
    if (tmo || got_d.size() != 1 || got_d[0] !== ~old) begin
      fails++;
      $display("FAIL ldhold_new got n=%0d d=%h want 1 %h",
               got_d.size(), got_d.size() ? got_d[0] : 64'd0, ~old);
    end
  endtask

  task automatic test_random();
    int lat, hb, sel; bit tmo;
    logic [63:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [1:0] b;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1) == 1)
        load_word($urandom_range(MW - 1), {$urandom, $urandom});
      sel = $urandom_range(9);
      b = (sel < 4) ? 2'd1 : (sel < 8) ? 2'd2 : (sel == 8) ? 2'd0 : 2'd3;
      if (b == 2'd2 && $urandom_range(5) != 0)
        l = 8'((2 << $urandom_range(3)) - 1);
      else
        l = 8'($urandom_range(15));
      s = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'd3;
      a = 64'($urandom_range(MW + 8)) << 3;
      model(a, l, s, b);
      do_burst(a, l, s, b, 25, -1, 0, -1, lat, hb, tmo);
      tests++;
      if (tmo || got_d.size() != exp_d.size() || hb != 0 || lat != LAT + 1) begin
        fails++;
        $display("FAIL rand%0d_shape got n=%0d hold=%0d lat=%0d tmo=%0d want n=%0d hold=0 lat=%0d",
                 k, got_d.size(), hb, lat, tmo, exp_d.size(), LAT + 1);
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        tests++;
        if (got_d[i] !== exp_d[i] || got_r[i] !== exp_r[i] || got_l[i] !== exp_l[i]) begin
          fails++;
          $display("FAIL rand%0d_beat%0d got d=%h r=%0d l=%b want d=%h r=%0d l=%b",
                   k, i, got_d[i], got_r[i], got_l[i], exp_d[i], exp_r[i], exp_l[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    arvalid = 1'b0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    rready = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    test_reset();
    for (int i = 0; i < MW; i++)
      load_word(i, (i < 16) ? 64'(i) : {$urandom, $urandom});
    test_wrap();
    test_incr();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    test_busy();
    test_load_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
